// File: rtl/rv32i_types.sv
// Shared rv32i pipeline types: register index and the stall controller's
// miss-completion state.
package rv32i_types;

  typedef logic [4:0] rv32i_reg;

  localparam rv32i_reg REG_ZERO = 5'd0;

  // RUN: no partial completion latched.
  // I_DONE: fetch already returned, data access still outstanding.
  // D_DONE: data access already returned, fetch still outstanding.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    I_DONE = 2'd1,
    D_DONE = 2'd2
  } stall_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear; sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end
    return v + CNT_W'(1);
  endfunction

  // Next count: bump on inc, holding at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (inc) begin
      count_d = sat_inc(count_q);
    end
  end

  // Count register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush controller for the 5-stage rv32i pipe. Freezes the whole pipe
// on I/D memory misses, inserts one bubble per load-use hazard, squashes the
// two younger stages on a taken redirect, and counts stalls and flushes.
module pipeline_stall_ctrl
  import rv32i_types::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_read,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  rv32i_reg         id_rs1,
  input  rv32i_reg         id_rs2,
  input  rv32i_reg         ex_rd,
  input  logic             ex_mem_read,
  input  logic             br_taken_ex,
  output logic             pc_load,
  output logic             if_id_load,
  output logic             id_ex_load,
  output logic             ex_mem_load,
  output logic             mem_wb_load,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  stall_state_t state_q;
  stall_state_t state_d;

  logic i_wait;
  logic d_wait;
  logic mem_stall;
  logic lu_haz;
  logic stall_inc;
  logic flush_inc;

  // A miss only keeps waiting if its completion has not already been latched.
  always_comb begin
    i_wait    = imem_read & ~imem_resp & (state_q != I_DONE);
    d_wait    = dmem_req & ~dmem_resp & (state_q != D_DONE);
    mem_stall = i_wait | d_wait;
    lu_haz    = ex_mem_read & (ex_rd != REG_ZERO) &
                ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  end

  // Next state: remember whichever response came first while the other miss
  // is still outstanding; both in one cycle means nothing needs remembering.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (imem_resp & dmem_req & ~dmem_resp) begin
          state_d = I_DONE;
        end else if (dmem_resp & imem_read & ~imem_resp) begin
          state_d = D_DONE;
        end
      end
      I_DONE: begin
        if (dmem_resp) begin
          state_d = RUN;
        end
      end
      D_DONE: begin
        if (imem_resp) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State register; reset drops any latched completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Load/flush enables in priority order: reset, memory freeze, redirect,
  // load-use bubble, free-running. Flushes only ever ride on an active load.
  always_comb begin
    pc_load     = 1'b1;
    if_id_load  = 1'b1;
    id_ex_load  = 1'b1;
    ex_mem_load = 1'b1;
    mem_wb_load = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (rst | mem_stall) begin
      pc_load     = 1'b0;
      if_id_load  = 1'b0;
      id_ex_load  = 1'b0;
      ex_mem_load = 1'b0;
      mem_wb_load = 1'b0;
    end else if (br_taken_ex) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (lu_haz) begin
      pc_load     = 1'b0;
      if_id_load  = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // Counter increment conditions; a redirect cancels the hazard bubble.
  always_comb begin
    stall_inc = ~rst & (mem_stall | (lu_haz & ~br_taken_ex));
    flush_inc = ~rst & ~mem_stall & br_taken_ex;
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed scenarios with literal expectations
// followed by protocol-respecting random traffic against a freeze-based model.
module tb_pipeline_stall_ctrl;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic imem_read, imem_resp, dmem_req, dmem_resp;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic ex_mem_read, br_taken_ex;
  logic pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
  logic if_id_flush, id_ex_flush;
  logic [CNT_W-1:0] stall_count, flush_count;

  pipeline_stall_ctrl #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_read   (imem_read),
    .imem_resp   (imem_resp),
    .dmem_req    (dmem_req),
    .dmem_resp   (dmem_resp),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .br_taken_ex (br_taken_ex),
    .pc_load     (pc_load),
    .if_id_load  (if_id_load),
    .id_ex_load  (id_ex_load),
    .ex_mem_load (ex_mem_load),
    .mem_wb_load (mem_wb_load),
    .if_id_flush (if_id_flush),
    .id_ex_flush (id_ex_flush),
    .stall_count (stall_count),
    .flush_count (flush_count)
  );

  always #5 clk = ~clk;

  logic [6:0] outs;
  assign outs = {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
                 if_id_flush, id_ex_flush};

  localparam logic [6:0] O_FREEZE = 7'b0000000;
  localparam logic [6:0] O_RUN    = 7'b1111100;
  localparam logic [6:0] O_BUBBLE = 7'b0011101;
  localparam logic [6:0] O_REDIR  = 7'b1111111;

  int n_chk  = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  // Behavioural model: while the pipe is frozen, remember which responses have
  // already arrived; the moment the pipe advances, everything is forgotten.
  logic m_i_got = 1'b0;
  logic m_d_got = 1'b0;
  int   m_stall = 0;
  int   m_flush = 0;

  function automatic logic model_frozen();
    return (imem_read && !imem_resp && !m_i_got) ||
           (dmem_req && !dmem_resp && !m_d_got);
  endfunction

  function automatic logic model_haz();
    return ex_mem_read && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  endfunction

  function automatic logic [6:0] model_exp();
    if (rst) return O_FREEZE;
    if (model_frozen()) return O_FREEZE;
    if (br_taken_ex) return O_REDIR;
    if (model_haz()) return O_BUBBLE;
    return O_RUN;
  endfunction

  function automatic int sat_add(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  // Model state advance on each clock edge.
  always @(posedge clk) begin
    if (rst) begin
      m_i_got <= 1'b0;
      m_d_got <= 1'b0;
      m_stall <= 0;
      m_flush <= 0;
    end else begin
      if (model_frozen()) begin
        m_i_got <= m_i_got | imem_resp;
        m_d_got <= m_d_got | dmem_resp;
      end else begin
        m_i_got <= 1'b0;
        m_d_got <= 1'b0;
      end
      if (model_frozen() || (model_haz() && !br_taken_ex)) m_stall <= sat_add(m_stall);
      if (!model_frozen() && br_taken_ex) m_flush <= sat_add(m_flush);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [CNT_W-1:0] es;
    logic [CNT_W-1:0] ef;
    if (chk_en) begin
      es = m_stall[CNT_W-1:0];
      ef = m_flush[CNT_W-1:0];
      n_chk++;
      if (outs !== model_exp()) begin
        n_fail++;
        $display("FAIL cycle_outs t=%0t: got %b, required %b", $time, outs, model_exp());
      end
      n_chk++;
      if (stall_count !== es) begin
        n_fail++;
        $display("FAIL cycle_stall_count t=%0t: got %0d, required %0d", $time, stall_count, es);
      end
      n_chk++;
      if (flush_count !== ef) begin
        n_fail++;
        $display("FAIL cycle_flush_count t=%0t: got %0d, required %0d", $time, flush_count, ef);
      end
    end
  end

  task automatic chk_out(input string nm, input logic [6:0] exp);
    n_chk++;
    if (outs !== exp) begin
      n_fail++;
      $display("FAIL %s: outputs %b, required %b", nm, outs, exp);
    end
  endtask

  task automatic chk_cnt(input string nm, input int exp_s, input int exp_f);
    n_chk++;
    if (stall_count !== CNT_W'(exp_s)) begin
      n_fail++;
      $display("FAIL %s stall_count: got %0d, required %0d", nm, stall_count, exp_s);
    end
    n_chk++;
    if (flush_count !== CNT_W'(exp_f)) begin
      n_fail++;
      $display("FAIL %s flush_count: got %0d, required %0d", nm, flush_count, exp_f);
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic i_busy;
    logic d_busy;
    rst = 1'b1;
    imem_read = 1'b0; imem_resp = 1'b0; dmem_req = 1'b0; dmem_resp = 1'b0;
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0; ex_mem_read = 1'b0; br_taken_ex = 1'b0;

    // Reset
    settle(); chk_out("reset_outs", O_FREEZE);
    tick(); chk_en = 1'b1;
    settle(); chk_out("reset_outs2", O_FREEZE); chk_cnt("reset_cnt", 0, 0);
    tick(); rst = 1'b0;

    // Idle pipe
    repeat (3) begin settle(); chk_out("idle", O_RUN); chk_cnt("idle_cnt", 0, 0); tick(); end

    // I-miss, response after 3 waiting cycles
    imem_read = 1'b1;
    repeat (3) begin settle(); chk_out("imiss_wait", O_FREEZE); tick(); end
    imem_resp = 1'b1;
    settle(); chk_out("imiss_resp", O_RUN); tick();
    imem_read = 1'b0; imem_resp = 1'b0;
    settle(); chk_cnt("imiss_cnt", 3, 0); tick();

    // I and D miss together: imem_resp at t+2, dmem_resp at t+5
    imem_read = 1'b1; dmem_req = 1'b1;
    repeat (2) begin settle(); chk_out("id_miss_wait", O_FREEZE); tick(); end
    imem_resp = 1'b1;
    settle(); chk_out("id_miss_iresp", O_FREEZE); tick();
    imem_resp = 1'b0; imem_read = 1'b0;
    repeat (2) begin settle(); chk_out("id_miss_idone", O_FREEZE); tick(); end
    dmem_resp = 1'b1;
    settle(); chk_out("id_miss_dresp", O_RUN); tick();
    dmem_resp = 1'b0; dmem_req = 1'b0;
    settle(); chk_cnt("id_miss_cnt", 8, 0); tick();

    // Load-use hazard on rs2, then the bubble, then an x0 destination
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs1 = 5'd1;
    settle(); chk_out("lu_haz", O_BUBBLE); tick();
    ex_mem_read = 1'b0;
    settle(); chk_out("lu_after", O_RUN); chk_cnt("lu_cnt", 9, 0); tick();
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    settle(); chk_out("lu_x0", O_RUN); tick();
    ex_mem_read = 1'b0;
    settle(); chk_cnt("lu_x0_cnt", 9, 0); tick();

    // Redirect together with a hazard
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; br_taken_ex = 1'b1;
    settle(); chk_out("br_haz", O_REDIR); tick();
    br_taken_ex = 1'b0; ex_mem_read = 1'b0;
    settle(); chk_cnt("br_haz_cnt", 9, 1); tick();

    // Enter D_DONE, reset with a stray imem_resp, then prove the state is RUN
    imem_read = 1'b1; dmem_req = 1'b1; dmem_resp = 1'b1;
    settle(); chk_out("dd_enter", O_FREEZE); tick();
    dmem_req = 1'b0; dmem_resp = 1'b0;
    settle(); chk_out("dd_hold", O_FREEZE); tick();
    rst = 1'b1; imem_resp = 1'b1;
    settle(); chk_out("dd_rst", O_FREEZE); tick();
    rst = 1'b0; imem_resp = 1'b0; imem_read = 1'b0; dmem_req = 1'b1;
    settle(); chk_out("post_rst_dwait", O_FREEZE); chk_cnt("post_rst_cnt", 0, 0); tick();
    dmem_resp = 1'b1;
    settle(); chk_out("post_rst_dresp", O_RUN); tick();
    dmem_req = 1'b0; dmem_resp = 1'b0;

    // Saturation of both counters
    ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3;
    repeat (CNT_MAX + 5) tick();
    ex_mem_read = 1'b0;
    settle(); chk_cnt("stall_sat", CNT_MAX, 0); tick();
    br_taken_ex = 1'b1;
    repeat (CNT_MAX + 5) tick();
    br_taken_ex = 1'b0;
    settle(); chk_cnt("flush_sat", CNT_MAX, CNT_MAX); tick();

    // Random traffic obeying the request/response handshake
    i_busy = 1'b0;
    d_busy = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      imem_resp = 1'b0;
      dmem_resp = 1'b0;
      if ($urandom_range(99) < 2) begin
        rst = 1'b1;
        i_busy = 1'b0;
        d_busy = 1'b0;
      end else begin
        rst = 1'b0;
        if (!i_busy && !m_i_got && !m_d_got && $urandom_range(99) < 25) i_busy = 1'b1;
        if (!d_busy && !m_i_got && !m_d_got && $urandom_range(99) < 20) d_busy = 1'b1;
      end
      imem_read = i_busy;
      dmem_req  = d_busy;
      if (i_busy && $urandom_range(99) < 35) begin imem_resp = 1'b1; i_busy = 1'b0; end
      if (d_busy && $urandom_range(99) < 35) begin dmem_resp = 1'b1; d_busy = 1'b0; end
      ex_mem_read = ($urandom_range(99) < 50);
      ex_rd       = 5'($urandom_range(3));
      id_rs1      = 5'($urandom_range(3));
      id_rs2      = 5'($urandom_range(3));
      br_taken_ex = ($urandom_range(99) < 12);
      tick();
    end

    rst = 1'b0; imem_read = 1'b0; imem_resp = 1'b0; dmem_req = 1'b0; dmem_resp = 1'b0;
    ex_mem_read = 1'b0; br_taken_ex = 1'b0;
    settle();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
